// File: rtl/tt_um_ishsub_serial.sv
// tt_um_ishsub_serial -- bit-serial subtractor tile.
//
// Computes A - B one bit per clock, LSB first, over WIDTH cycles. A and B
// are captured from ui_in by the load strobes on uio_in[1:0]. A rising edge
// on uio_in[2] starts an operation. The difference is registered on uo_out.
// done, borrow and busy are reported on uio_out[7:5].
//
// Optional feature macro: SUB_SATURATE_EN
//   When defined, a result that borrows (A < B) is clamped to zero on uo_out.
//   The borrow flag is still reported. When undefined, uo_out always carries
//   the modular difference.
module tt_um_ishsub_serial #(
    parameter int WIDTH = 8    // operand/result width, legal range 1..8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // The count of the final serial step, at which the result is committed.
    localparam logic [3:0] CNT_LAST = 4'(WIDTH - 1);

    // ------------------------------------------------------------------
    // Control inputs
    // ------------------------------------------------------------------
    logic load_a;
    logic load_b;
    logic start;

    assign load_a = uio_in[0];
    assign load_b = uio_in[1];
    assign start  = uio_in[2];

    // ena and uio_in[7:3] carry no function on this tile.
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:3]};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q,      state_d;
    logic [WIDTH-1:0]   a_q,          a_d;
    logic [WIDTH-1:0]   b_q,          b_d;
    logic [WIDTH-1:0]   sh_a_q,       sh_a_d;
    logic [WIDTH-1:0]   sh_b_q,       sh_b_d;
    logic [WIDTH-1:0]   res_q,        res_d;
    logic [WIDTH-1:0]   out_q,        out_d;
    logic [3:0]         cnt_q,        cnt_d;
    logic               bacc_q,       bacc_d;
    logic               borrow_q,     borrow_d;
    logic               done_q,       done_d;
    logic               busy_q,       busy_d;
    logic               start_q;

    // ------------------------------------------------------------------
    // Derived signals
    // ------------------------------------------------------------------
    logic               trigger;      // one-cycle pulse on start rising edge
    logic               accept_load;  // operands may be rewritten
    logic               last_step;    // current RUN edge is the final bit
    logic               bit_a;
    logic               bit_b;
    logic               diff_bit;
    logic               borrow_next;
    logic [WIDTH-1:0]   res_shift;    // result register after this step
    logic [WIDTH-1:0]   final_value;  // value committed to uo_out

    assign trigger     = start & ~start_q;
    assign accept_load = (state_q != S_RUN);
    assign last_step   = (cnt_q == CNT_LAST);

    // One full-subtractor slice; the borrow chain is carried in bacc_q.
    assign bit_a       = sh_a_q[0];
    assign bit_b       = sh_b_q[0];
    assign diff_bit    = bit_a ^ bit_b ^ bacc_q;
    assign borrow_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bacc_q);

    // Each new difference bit enters at the MSB, so after WIDTH steps the
    // first (LSB) bit has travelled down to bit 0.
    assign res_shift   = (res_q >> 1) | (WIDTH'(diff_bit) << (WIDTH - 1));

`ifdef SUB_SATURATE_EN
    assign final_value = borrow_next ? '0 : res_shift;
`else
    assign final_value = res_shift;
`endif

    // ------------------------------------------------------------------
    // Next-state logic for the sequencing FSM
    // ------------------------------------------------------------------
    // NOTE: every output of an always_comb gets a default before any branch,
    //       so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE,
            S_DONE: begin
                if (trigger) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand registers: written by the load strobes outside RUN only.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (accept_load) begin
            if (load_a) begin
                a_d = ui_in[WIDTH-1:0];
            end
            if (load_b) begin
                b_d = ui_in[WIDTH-1:0];
            end
        end
    end

    // Serial datapath and status flags, driven by the current FSM state.
    always_comb begin
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        res_d    = res_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        bacc_d   = bacc_q;
        borrow_d = borrow_q;
        done_d   = done_q;
        busy_d   = busy_q;

        unique case (state_q)
            S_IDLE,
            S_DONE: begin
                // The shift registers take the operand values held before
                // this edge, even if a load lands on the same edge.
                if (trigger) begin
                    sh_a_d = a_q;
                    sh_b_d = b_q;
                    res_d  = '0;
                    cnt_d  = '0;
                    bacc_d = 1'b0;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                end
            end
            S_RUN: begin
                sh_a_d = sh_a_q >> 1;
                sh_b_d = sh_b_q >> 1;
                res_d  = res_shift;
                bacc_d = borrow_next;
                cnt_d  = cnt_q + 4'd1;
                if (last_step) begin
                    out_d    = final_value;
                    borrow_d = borrow_next;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers with synchronous active-low reset
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    //       samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            res_q    <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            bacc_q   <= 1'b0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            res_q    <= res_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            bacc_q   <= bacc_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            start_q  <= start;
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    // Zero-extend the WIDTH-bit result onto the 8-bit output bus.
    always_comb begin
        uo_out              = '0;
        uo_out[WIDTH-1:0]   = out_q;
    end

    assign uio_out = {done_q, borrow_q, busy_q, 5'b0_0000};
    assign uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_um_ishsub_serial.sv
// Self-checking bench for tt_um_ishsub_serial (default WIDTH=8).
// Expected results come from plain integer arithmetic on the loaded operands.
module tb_tt_um_ishsub_serial;

    localparam int W = 8;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    // Reference copies of the operand registers.
    logic [7:0] model_a;
    logic [7:0] model_b;

    tt_um_ishsub_serial #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: difference modulo 2^W and the unsigned borrow.
    function automatic logic [7:0] ref_value(input logic [7:0] a, input logic [7:0] b);
        int mod;
        int diff;
        int res;
        mod  = 1 << W;
        diff = int'(a) % mod - int'(b) % mod;
        res  = (diff + mod) % mod;
`ifdef SUB_SATURATE_EN
        if (diff < 0) res = 0;
`endif
        return 8'(res);
    endfunction

    function automatic logic ref_borrow(input logic [7:0] a, input logic [7:0] b);
        return (int'(a) % (1 << W)) < (int'(b) % (1 << W));
    endfunction

    // Load A then B on consecutive cycles (inputs driven at negedge).
    task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk); ui_in = a; uio_in = 8'h01;
        @(negedge clk); ui_in = b; uio_in = 8'h02;
        @(negedge clk); uio_in = 8'h00;
        model_a = a;
        model_b = b;
    endtask

    // Drive a start edge (with optional extra strobes) at the next negedge,
    // wait a bounded time for done and check result, borrow and busy length.
    // With meddle set, start is toggled and load_a=0x99 is driven during RUN.
    task automatic run_op(input string tag, input logic [7:0] first_uio,
                          input logic [7:0] exp_a, input logic [7:0] exp_b,
                          input bit meddle);
        int  busy_n;
        bit  seen;
        busy_n = 0;
        seen   = 1'b0;
        @(negedge clk); uio_in = first_uio;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                uio_in = 8'h00;
                check({tag, " done_drop"}, uio_out[7], 1'b0);
            end
            if (meddle && i >= 1 && i <= 5) begin
                ui_in  = 8'h99;
                uio_in = (i % 2 == 1) ? 8'h05 : 8'h01;
            end
            if (meddle && i == 6) uio_in = 8'h00;
            if (uio_out[7]) begin
                seen = 1'b1;
                break;
            end
            if (uio_out[5]) busy_n++;
        end
        uio_in = 8'h00;
        check({tag, " done"},   seen, 1'b1);
        check({tag, " busy_n"}, busy_n, W);
        check({tag, " uo_out"}, uo_out, ref_value(exp_a, exp_b));
        check({tag, " borrow"}, uio_out[6], ref_borrow(exp_a, exp_b));
        check({tag, " busy_off"}, uio_out[5], 1'b0);
    endtask

    initial begin
        int  busy_n;
        int  rises;
        bit  prev_done;
        bit  seen;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] v;

        ena     = 1'b1;
        rst_n   = 1'b0;
        ui_in   = 8'h00;
        uio_in  = 8'h00;
        model_a = 8'h00;
        model_b = 8'h00;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset uo_out",  uo_out,  8'h00);
        check("reset uio_out", uio_out, 8'h00);
        check("reset uio_oe",  uio_oe,  8'hE0);
        rst_n = 1'b1;

        // Directed arithmetic cases.
        load_ops(8'h50, 8'h20); run_op("50-20", 8'h04, model_a, model_b, 1'b0);
        check("status low bits", uio_out[4:0], 5'b0);
        load_ops(8'h20, 8'h50); run_op("20-50", 8'h04, model_a, model_b, 1'b0);
        load_ops(8'hFF, 8'h01); run_op("FF-01", 8'h04, model_a, model_b, 1'b0);

        // Loads in DONE leave the reported result untouched.
        @(negedge clk); ui_in = 8'h33; uio_in = 8'h03;
        @(negedge clk); uio_in = 8'h00;
        model_a = 8'h33; model_b = 8'h33;
        check("load keeps uo_out", uo_out,     ref_value(8'hFF, 8'h01));
        check("load keeps done",   uio_out[7], 1'b1);
        check("load keeps borrow", uio_out[6], 1'b0);
        run_op("both-load same", 8'h04, model_a, model_b, 1'b0);

        load_ops(8'h00, 8'h00); run_op("00-00", 8'h04, model_a, model_b, 1'b0);

        // Start held high for 20 cycles triggers exactly one operation.
        load_ops(8'h9C, 8'h3A);
        @(negedge clk); uio_in = 8'h04;
        busy_n = 0; rises = 0; prev_done = uio_out[7];
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uio_out[5]) busy_n++;
            if (uio_out[7] && !prev_done) rises++;
            prev_done = uio_out[7];
        end
        uio_in = 8'h00;
        check("held start busy_n", busy_n, W);
        check("held start rises",  rises,  1);
        check("held start uo_out", uo_out, ref_value(8'h9C, 8'h3A));

        // Start toggles and load_a during RUN are ignored.
        load_ops(8'h80, 8'h10);
        run_op("meddle", 8'h04, model_a, model_b, 1'b1);
        run_op("meddle rerun", 8'h04, model_a, model_b, 1'b0);

        // Load and trigger on the same edge: old operands are used.
        load_ops(8'hC4, 8'h47);
        run_op("coincide", 8'h07, 8'hC4, 8'h47, 1'b0);
        model_a = 8'h00; model_b = 8'h00;
        run_op("coincide after", 8'h04, model_a, model_b, 1'b0);

        // Reset mid-RUN aborts the operation and clears the operands.
        load_ops(8'hA5, 8'h5A);
        @(negedge clk); uio_in = 8'h04;
        repeat (4) @(negedge clk);
        uio_in = 8'h00;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        check("abort uo_out",  uo_out,  8'h00);
        check("abort uio_out", uio_out, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (uio_out[7] || uio_out[5]) seen = 1'b1;
        end
        check("abort no done", seen, 1'b0);
        model_a = 8'h00; model_b = 8'h00;
        run_op("after abort cleared", 8'h04, model_a, model_b, 1'b0);
        load_ops(8'h3C, 8'h7E); run_op("after abort", 8'h04, model_a, model_b, 1'b0);

        // Back-to-back restarts from DONE with random operands.
        for (int n = 0; n < 16; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (n % 4 == 0) begin
                v = ra;
                rb = ra;
            end
            load_ops(ra, rb);
            run_op($sformatf("rand%0d", n), 8'h04, model_a, model_b, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
